// File: rtl/requant_unit.sv
// requant_unit: three-stage INT32 -> INT8 requantization pipeline.
// Each beat gets bias added, a fixed-point scale, a rounding right shift,
// optional ReLU and INT8 saturation. Config is snapshotted per beat.
module requant_unit #(
    parameter int ACC_W   = 32,
    parameter int MULT_W  = 16,
    parameter int SHIFT_W = 5,
    parameter int OUT_W   = 8,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_load,
    input  logic [MULT_W-1:0]        cfg_mult,
    input  logic [SHIFT_W-1:0]       cfg_shift,
    input  logic                     cfg_relu,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [ACC_W-1:0]  in_acc,
    input  logic signed [ACC_W-1:0]  in_bias,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic [CNT_W-1:0]         sat_count,
    input  logic                     sat_clr
);

    localparam int SUM_W  = ACC_W + 1;
    localparam int PROD_W = SUM_W + MULT_W + 1;
    localparam int RND_W  = PROD_W + 1;
    localparam logic signed [RND_W-1:0] OUT_MAX = (RND_W'(1) <<< (OUT_W - 1)) - RND_W'(1);
    localparam logic signed [RND_W-1:0] OUT_MIN = ~OUT_MAX;

    // Live configuration registers
    logic [MULT_W-1:0]  mult_q;
    logic [SHIFT_W-1:0] shift_q;
    logic               relu_q;

    // Stage 1: biased sum plus config snapshot
    logic                    v1_q, last1_q, relu1_q;
    logic signed [SUM_W-1:0] sum1_q;
    logic [MULT_W-1:0]       mult1_q;
    logic [SHIFT_W-1:0]      shift1_q;

    // Stage 2: scaled product
    logic                     v2_q, last2_q, relu2_q;
    logic signed [PROD_W-1:0] prod2_q;
    logic [SHIFT_W-1:0]       shift2_q;

    // Stage 3: final INT8 result
    logic                    v3_q, last3_q, sat3_q;
    logic signed [OUT_W-1:0] data3_q;
    logic [CNT_W-1:0]        satCnt_q;

    logic                     ld1, ld2, ld3;
    logic signed [SUM_W-1:0]  sum_d;
    logic signed [PROD_W-1:0] prod_d;
    logic signed [RND_W-1:0]  half_d, rnd_d, clip_d;
    logic signed [OUT_W-1:0]  data_d;
    logic                     sat_d;

    // A stage advances when it is empty or the stage after it is advancing.
    assign ld3      = !v3_q || out_ready;
    assign ld2      = !v2_q || ld3;
    assign ld1      = !v1_q || ld2;
    assign in_ready = ld1;

    assign out_valid = v3_q;
    assign out_data  = data3_q;
    assign out_last  = last3_q;
    assign busy      = v1_q || v2_q || v3_q;
    assign sat_count = satCnt_q;

    assign sum_d  = SUM_W'(in_acc) + SUM_W'(in_bias);
    assign prod_d = PROD_W'(sum1_q) * PROD_W'($signed({1'b0, mult1_q}));

    // Round half toward +inf, arithmetic shift, optional ReLU, clamp to INT8.
    always_comb begin
        half_d = '0;
        if (shift2_q != '0) begin
            half_d[shift2_q - SHIFT_W'(1)] = 1'b1;
        end
        rnd_d  = RND_W'(prod2_q) + half_d;
        clip_d = rnd_d >>> shift2_q;
        if (relu2_q && clip_d[RND_W-1]) begin
            clip_d = '0;
        end
        sat_d  = 1'b0;
        data_d = clip_d[OUT_W-1:0];
        if (clip_d > OUT_MAX) begin
            data_d = OUT_MAX[OUT_W-1:0];
            sat_d  = 1'b1;
        end else if (clip_d < OUT_MIN) begin
            data_d = OUT_MIN[OUT_W-1:0];
            sat_d  = 1'b1;
        end
    end

    // Config registers; a beat accepted on the load cycle still sees old values.
    always_ff @(posedge clk) begin
        if (rst) begin
            mult_q  <= MULT_W'(1);
            shift_q <= '0;
            relu_q  <= 1'b0;
        end else if (cfg_load) begin
            mult_q  <= cfg_mult;
            shift_q <= cfg_shift;
            relu_q  <= cfg_relu;
        end
    end

    // Stage 1 register: accept a beat and snapshot the config it will use.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q     <= 1'b0;
            last1_q  <= 1'b0;
            relu1_q  <= 1'b0;
            sum1_q   <= '0;
            mult1_q  <= '0;
            shift1_q <= '0;
        end else if (ld1) begin
            v1_q <= in_valid;
            if (in_valid) begin
                sum1_q   <= sum_d;
                mult1_q  <= mult_q;
                shift1_q <= shift_q;
                relu1_q  <= relu_q;
                last1_q  <= in_last;
            end
        end
    end

    // Stage 2 register: scaled product and remaining per-beat config.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q     <= 1'b0;
            last2_q  <= 1'b0;
            relu2_q  <= 1'b0;
            prod2_q  <= '0;
            shift2_q <= '0;
        end else if (ld2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                prod2_q  <= prod_d;
                shift2_q <= shift1_q;
                relu2_q  <= relu1_q;
                last2_q  <= last1_q;
            end
        end
    end

    // Stage 3 register: output beat, held steady while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            v3_q    <= 1'b0;
            last3_q <= 1'b0;
            sat3_q  <= 1'b0;
            data3_q <= '0;
        end else if (ld3) begin
            v3_q <= v2_q;
            if (v2_q) begin
                data3_q <= data_d;
                last3_q <= last2_q;
                sat3_q  <= sat_d;
            end
        end
    end

    // Saturation counter: counts clamped beats as they leave, sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            satCnt_q <= '0;
        end else if (sat_clr) begin
            satCnt_q <= '0;
        end else if (v3_q && out_ready && sat3_q && (satCnt_q != '1)) begin
            satCnt_q <= satCnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_requant_unit.sv
// tb_requant_unit: directed vectors with a scoreboard queue; a negedge
// monitor pops expected beats and also checks that stalled outputs hold.
module tb_requant_unit;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_load;
    logic [15:0]        cfg_mult;
    logic [4:0]         cfg_shift;
    logic               cfg_relu;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] in_acc;
    logic signed [31:0] in_bias;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic signed [7:0]  out_data;
    logic               out_last;
    logic               busy;
    logic [15:0]        sat_count;
    logic               sat_clr;

    typedef struct {
        logic signed [7:0] data;
        logic              last;
    } expT;

    expT expQ[$];
    int  compareCount = 0;
    int  missCount    = 0;

    logic              stallPrev = 1'b0;
    logic signed [7:0] heldData;
    logic              heldLast;

    requant_unit dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_load  (cfg_load),
        .cfg_mult  (cfg_mult),
        .cfg_shift (cfg_shift),
        .cfg_relu  (cfg_relu),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_acc    (in_acc),
        .in_bias   (in_bias),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .sat_count (sat_count),
        .sat_clr   (sat_clr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        compareCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Present one beat, wait (bounded) for acceptance, optionally push its expectation.
    task automatic applyStimulus(input logic signed [31:0] acc, input logic signed [31:0] bias,
                                 input logic last, input logic signed [7:0] expData, input logic push);
        int  waitCycles = 0;
        bit  accepted   = 1'b0;
        expT e;
        in_valid = 1'b1;
        in_acc   = acc;
        in_bias  = bias;
        in_last  = last;
        while (!accepted && waitCycles < 300) begin
            @(negedge clk);
            if (in_ready) accepted = 1'b1;
            else waitCycles++;
        end
        if (!accepted) begin
            checkOutput("accept_timeout", 0, 1);
        end else if (push) begin
            e.data = expData;
            e.last = last;
            expQ.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic cfgLoad(input logic [15:0] mult, input logic [4:0] shift, input logic relu);
        cfg_load  = 1'b1;
        cfg_mult  = mult;
        cfg_shift = shift;
        cfg_relu  = relu;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while ((expQ.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, expQ.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare on each transfer; verify stalled beats stay put.
    always @(negedge clk) begin
        if (rst) begin
            stallPrev = 1'b0;
        end else begin
            if (stallPrev) begin
                checkOutput("stall_valid", out_valid, 1);
                checkOutput("stall_data", out_data, heldData);
                checkOutput("stall_last", out_last, heldLast);
            end
            stallPrev = out_valid && !out_ready;
            heldData  = out_data;
            heldLast  = out_last;
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_beat", out_data, 999);
                end else begin
                    expT e;
                    e = expQ.pop_front();
                    checkOutput("out_data", out_data, e.data);
                    checkOutput("out_last", out_last, e.last);
                end
            end
        end
    end

    initial begin
        #2000000;
        checkOutput("global_timeout", 0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", compareCount, missCount);
        $finish;
    end

    initial begin
        rst = 1'b1; cfg_load = 1'b0; cfg_mult = '0; cfg_shift = '0; cfg_relu = 1'b0;
        in_valid = 1'b0; in_acc = '0; in_bias = '0; in_last = 1'b0;
        out_ready = 1'b1; sat_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_sat_count", sat_count, 0);
        checkOutput("rst_out_data", out_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Default config: identity with saturation
        applyStimulus(100, 0, 1'b0, 100, 1'b1);
        applyStimulus(1000, 0, 1'b0, 127, 1'b1);
        applyStimulus(-1000, 0, 1'b0, -128, 1'b1);
        waitDrain("drain_defaults");
        checkOutput("sat_after_defaults", sat_count, 2);

        // Scale 3, shift 2
        cfgLoad(3, 2, 1'b0);
        applyStimulus(10, 5, 1'b0, 11, 1'b1);
        applyStimulus(-10, 0, 1'b0, -7, 1'b1);
        applyStimulus(-11, 0, 1'b0, -8, 1'b1);

        // Scale 1, shift 2: half-way values round toward +inf; loaded while busy
        cfgLoad(1, 2, 1'b0);
        applyStimulus(-10, 0, 1'b0, -2, 1'b1);
        applyStimulus(-11, 0, 1'b0, -3, 1'b1);
        applyStimulus(-9, 0, 1'b0, -2, 1'b1);
        applyStimulus(2, 0, 1'b0, 1, 1'b1);

        // ReLU on, shift 1
        cfgLoad(1, 1, 1'b1);
        applyStimulus(-50, 0, 1'b0, 0, 1'b1);
        applyStimulus(300, 0, 1'b0, 127, 1'b1);
        applyStimulus(5, 0, 1'b0, 3, 1'b1);
        waitDrain("drain_relu");
        checkOutput("sat_after_relu", sat_count, 3);

        // Full-scale multiplier
        cfgLoad(16'hFFFF, 16, 1'b0);
        applyStimulus(100, 0, 1'b0, 100, 1'b1);
        applyStimulus(-1, 0, 1'b0, -1, 1'b1);
        applyStimulus(200, 0, 1'b0, 127, 1'b1);

        // Extreme sums and maximum shift
        cfgLoad(1, 31, 1'b0);
        applyStimulus(32'sh7FFFFFFF, 32'sh7FFFFFFF, 1'b0, 2, 1'b1);
        applyStimulus(32'sh80000000, 32'sh80000000, 1'b0, -2, 1'b1);
        applyStimulus(32'sh7FFFFFFF, 0, 1'b0, 1, 1'b1);
        waitDrain("drain_extremes");
        checkOutput("sat_after_extremes", sat_count, 4);

        // Backpressure: fill with consumer stalled, then random out_ready
        cfgLoad(1, 0, 1'b0);
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) applyStimulus(i, 0, 1'b0, 8'(i), 1'b1);
        @(negedge clk);
        checkOutput("full_in_ready", in_ready, 0);
        checkOutput("full_busy", busy, 1);
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 4; i <= 6; i++) applyStimulus(i, 0, (i == 6), 8'(i), 1'b1);
            end
            begin
                for (int k = 0; k < 30; k++) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        waitDrain("drain_backpressure");

        // cfg_load coinciding with acceptance of beat A; beat B sees the new shift
        @(negedge clk);
        checkOutput("coincide_ready", in_ready, 1);
        @(posedge clk);
        #1;
        cfg_load = 1'b1; cfg_mult = 1; cfg_shift = 1; cfg_relu = 1'b0;
        applyStimulus(9, 0, 1'b0, 9, 1'b1);
        cfg_load = 1'b0;
        applyStimulus(9, 0, 1'b0, 5, 1'b1);
        waitDrain("drain_coincide");

        // sat_clr in the same cycle a saturating beat leaves
        out_ready = 1'b0;
        applyStimulus(1000, 0, 1'b0, 127, 1'b1);
        begin
            int n = 0;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            checkOutput("satclr_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        sat_clr   = 1'b1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
        waitDrain("drain_satclr");
        checkOutput("sat_after_clr", sat_count, 0);

        // Reset with beats in flight and a non-default config
        cfgLoad(1, 3, 1'b0);
        applyStimulus(2000, 0, 1'b0, 127, 1'b1);
        waitDrain("drain_prereset");
        checkOutput("sat_prereset", sat_count, 1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(50, 0, 1'b0, 0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("inflight_rst_out_valid", out_valid, 0);
        checkOutput("inflight_rst_busy", busy, 0);
        checkOutput("inflight_rst_sat", sat_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        applyStimulus(7, 0, 1'b1, 7, 1'b1);
        waitDrain("drain_postreset");

        $display("== %0d vectors applied, %0d miscompares ==", compareCount, missCount);
        $finish;
    end

endmodule
